// File: rtl/pool_pkg.sv
// Shared types and constants for the average-pooling engine.
package pool_pkg;

    localparam int unsigned LINE_BYTES = 32;
    localparam int unsigned RES_W      = 8;

    typedef logic [LINE_BYTES-1:0][7:0] line_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_CALC,
        S_WR_REQ,
        S_DONE
    } pool_state_t;

    function automatic int unsigned sum_width(input int unsigned log2_rows,
                                              input int unsigned log2_cols);
        return RES_W + log2_rows + log2_cols;
    endfunction

    // Window sizes are powers of two, so the highest set bit is the exponent.
    function automatic logic [5:0] log2_pow2(input logic [31:0] v);
        logic [5:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (v[i]) r = 6'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/pool_window_acc.sv
// Per-window datapath: sums the first y_n bytes of each read line into an
// accumulator and produces the floor average by shifting.
module pool_window_acc
    import pool_pkg::*;
#(
    parameter int unsigned Y_COLS_NUM      = 8,
    parameter int unsigned Y_LOG2_COLS_NUM = 3,
    parameter int unsigned SUM_W           = 14
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_clear,
    input  logic                      i_add,
    input  logic                      i_calc,
    input  logic [Y_COLS_NUM*8-1:0]   i_line,
    input  logic [Y_LOG2_COLS_NUM:0]  i_y_n,
    input  logic [5:0]                i_shift,
    output logic [RES_W-1:0]          o_result
);

    logic [SUM_W-1:0] r_sum;
    logic [SUM_W-1:0] w_line_sum;
    logic [RES_W-1:0] r_result;

    always_comb begin
        w_line_sum = '0;
        for (int unsigned j = 0; j < Y_COLS_NUM; j++) begin
            if (j < 32'(i_y_n)) w_line_sum = w_line_sum + SUM_W'(i_line[j*8 +: 8]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum    <= '0;
            r_result <= '0;
        end else begin
            if (i_clear)     r_sum <= '0;
            else if (i_add)  r_sum <= r_sum + w_line_sum;
            if (i_calc)      r_result <= RES_W'(r_sum >> i_shift);
        end
    end

    assign o_result = r_result;

endmodule

// File: rtl/pool_engine.sv
// Sliding-window average-pooling engine: reads one window row per request,
// averages each window and writes one byte per window.
module pool_engine
    import pool_pkg::*;
#(
    parameter int unsigned JUMP_COL        = 1,
    parameter int unsigned JUMP_ROW        = 1,
    parameter int unsigned ADDR_WIDTH      = 19,
    parameter int unsigned X_ROWS_NUM      = 128,
    parameter int unsigned X_COLS_NUM      = 128,
    parameter int unsigned X_LOG2_ROWS_NUM = $clog2(X_ROWS_NUM),
    parameter int unsigned X_LOG2_COLS_NUM = $clog2(X_COLS_NUM),
    parameter int unsigned Y_ROWS_NUM      = 8,
    parameter int unsigned Y_COLS_NUM      = 8,
    parameter int unsigned Y_LOG2_ROWS_NUM = $clog2(Y_ROWS_NUM),
    parameter int unsigned Y_LOG2_COLS_NUM = $clog2(Y_COLS_NUM)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_WIDTH-1:0]      sw_pool_addr_x,
    input  logic [ADDR_WIDTH-1:0]      sw_pool_addr_z,
    input  logic [X_LOG2_ROWS_NUM:0]   sw_pool_x_m,
    input  logic [X_LOG2_COLS_NUM:0]   sw_pool_x_n,
    input  logic [Y_LOG2_ROWS_NUM:0]   sw_pool_y_m,
    input  logic [Y_LOG2_COLS_NUM:0]   sw_pool_y_n,
    input  logic                       sw_pool_go,
    output logic                       sw_pool_done,
    output logic                       pool_sw_busy_ind,
    output logic                       rd_mem_req,
    output logic [ADDR_WIDTH-1:0]      rd_mem_start_addr,
    output logic [ADDR_WIDTH-1:0]      rd_mem_size_bytes,
    input  logic                       rd_mem_valid,
    input  logic                       rd_last,
    input  logic [255:0]               rd_mem_data,
    input  logic [4:0]                 rd_mem_last_valid,
    output logic                       wr_mem_req,
    output logic [ADDR_WIDTH-1:0]      wr_mem_start_addr,
    output logic [ADDR_WIDTH-1:0]      wr_mem_size_bytes,
    output logic [255:0]               wr_mem_data,
    input  logic                       wr_mem_ack,
    output logic [31:0]                data2write_out
);

    localparam int unsigned AW    = ADDR_WIDTH;
    localparam int unsigned XRW   = X_LOG2_ROWS_NUM + 1;
    localparam int unsigned XCW   = X_LOG2_COLS_NUM + 1;
    localparam int unsigned YRW   = Y_LOG2_ROWS_NUM + 1;
    localparam int unsigned SUM_W = sum_width(Y_LOG2_ROWS_NUM, Y_LOG2_COLS_NUM);

    pool_state_t r_state, w_next;

    logic           r_go_d;
    logic           w_go_rise;
    logic [AW-1:0]  r_addr_x, r_addr_z;
    logic [XCW-1:0] r_x_n;
    logic [YRW-1:0] r_y_m;
    logic [Y_LOG2_COLS_NUM:0] r_y_n;
    logic [5:0]     r_shift;
    logic [XRW-1:0] r_out_rows, r_row;
    logic [XCW-1:0] r_out_cols, r_col;
    logic [YRW-1:0] r_u;
    logic [AW-1:0]  r_rd_addr, r_rd_size, r_wr_addr, r_wr_size;
    logic [AW-1:0]  w_rd_addr, w_wr_addr;
    logic           w_last_u, w_last_win;
    logic [RES_W-1:0] w_result;
    line_t          w_rd_line;
    logic           w_unused;

    assign w_go_rise  = sw_pool_go & ~r_go_d;
    assign w_last_u   = (r_u == r_y_m - 1'b1);
    assign w_last_win = (r_row == r_out_rows - 1'b1) && (r_col == r_out_cols - 1'b1);

    assign w_rd_addr = r_addr_x
                     + (AW'(r_row) * AW'(JUMP_ROW) + AW'(r_u)) * AW'(r_x_n)
                     + AW'(r_col) * AW'(JUMP_COL);
    assign w_wr_addr = r_addr_z + AW'(r_row) * AW'(r_out_cols) + AW'(r_col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_go_rise) w_next = S_RD_REQ;
            S_RD_REQ:  w_next = S_RD_WAIT;
            S_RD_WAIT: if (rd_mem_valid) w_next = w_last_u ? S_CALC : S_RD_REQ;
            S_CALC:    w_next = S_WR_REQ;
            S_WR_REQ:  if (wr_mem_ack) w_next = w_last_win ? S_DONE : S_RD_REQ;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_go_d     <= 1'b0;
            r_addr_x   <= '0;
            r_addr_z   <= '0;
            r_x_n      <= '0;
            r_y_m      <= '0;
            r_y_n      <= '0;
            r_shift    <= '0;
            r_out_rows <= '0;
            r_out_cols <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_u        <= '0;
            r_rd_addr  <= '0;
            r_rd_size  <= '0;
            r_wr_addr  <= '0;
            r_wr_size  <= '0;
        end else begin
            r_go_d <= sw_pool_go;
            case (r_state)
                S_IDLE: if (w_go_rise) begin
                    r_addr_x   <= sw_pool_addr_x;
                    r_addr_z   <= sw_pool_addr_z;
                    r_x_n      <= sw_pool_x_n;
                    r_y_m      <= sw_pool_y_m;
                    r_y_n      <= sw_pool_y_n;
                    r_rd_size  <= AW'(sw_pool_y_n);
                    r_shift    <= log2_pow2(32'(sw_pool_y_m)) + log2_pow2(32'(sw_pool_y_n));
                    r_out_rows <= XRW'((32'(sw_pool_x_m) - 32'(sw_pool_y_m)) / JUMP_ROW + 1);
                    r_out_cols <= XCW'((32'(sw_pool_x_n) - 32'(sw_pool_y_n)) / JUMP_COL + 1);
                    r_row      <= '0;
                    r_col      <= '0;
                    r_u        <= '0;
                end
                S_RD_REQ:  r_rd_addr <= w_rd_addr;
                S_RD_WAIT: if (rd_mem_valid) r_u <= r_u + 1'b1;
                S_CALC: begin
                    r_wr_addr <= w_wr_addr;
                    r_wr_size <= AW'(1);
                end
                S_WR_REQ: if (wr_mem_ack) begin
                    r_u <= '0;
                    if (r_col == r_out_cols - 1'b1) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_rd_line = rd_mem_data;

    pool_window_acc #(
        .Y_COLS_NUM      (Y_COLS_NUM),
        .Y_LOG2_COLS_NUM (Y_LOG2_COLS_NUM),
        .SUM_W           (SUM_W)
    ) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  ((r_state == S_IDLE && w_go_rise) || (r_state == S_WR_REQ && wr_mem_ack)),
        .i_add    (r_state == S_RD_WAIT && rd_mem_valid),
        .i_calc   (r_state == S_CALC),
        .i_line   (w_rd_line[Y_COLS_NUM-1:0]),
        .i_y_n    (r_y_n),
        .i_shift  (r_shift),
        .o_result (w_result)
    );

    // Bytes beyond the widest window, rd_last and rd_mem_last_valid carry nothing we need.
    if (Y_COLS_NUM < LINE_BYTES) begin : g_unused_hi
        assign w_unused = ^{rd_last, rd_mem_last_valid, w_rd_line[LINE_BYTES-1:Y_COLS_NUM]};
    end else begin : g_unused_lo
        assign w_unused = ^{rd_last, rd_mem_last_valid};
    end

    assign rd_mem_req        = (r_state == S_RD_WAIT);
    assign rd_mem_start_addr = r_rd_addr;
    assign rd_mem_size_bytes = r_rd_size;
    assign wr_mem_req        = (r_state == S_WR_REQ);
    assign wr_mem_start_addr = r_wr_addr;
    assign wr_mem_size_bytes = r_wr_size;
    assign wr_mem_data       = 256'(w_result);
    assign data2write_out    = 32'(w_result);
    assign sw_pool_done      = (r_state == S_DONE);
    assign pool_sw_busy_ind  = (r_state != S_IDLE);

endmodule

// File: tb/tb_pool_engine.sv
// Randomised bench for pool_engine: a memory responder with variable
// latencies checks every request against window lists built from a picture model.
module tb_pool_engine;

    localparam int AW    = 19;
    localparam int JC    = 1;
    localparam int JR    = 1;
    localparam int LIMIT = 40000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] sw_pool_addr_x = '0, sw_pool_addr_z = '0;
    logic [7:0]    sw_pool_x_m = '0, sw_pool_x_n = '0;
    logic [3:0]    sw_pool_y_m = '0, sw_pool_y_n = '0;
    logic          sw_pool_go = 1'b0;
    logic          sw_pool_done, pool_sw_busy_ind;
    logic          rd_mem_req;
    logic [AW-1:0] rd_mem_start_addr, rd_mem_size_bytes;
    logic          rd_mem_valid = 1'b0, rd_last = 1'b0;
    logic [255:0]  rd_mem_data = '0;
    logic [4:0]    rd_mem_last_valid = '0;
    logic          wr_mem_req;
    logic [AW-1:0] wr_mem_start_addr, wr_mem_size_bytes;
    logic [255:0]  wr_mem_data;
    logic          wr_mem_ack = 1'b0;
    logic [31:0]   data2write_out;

    always #5 clk = ~clk;

    pool_engine #(.JUMP_COL(JC), .JUMP_ROW(JR), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .sw_pool_addr_x(sw_pool_addr_x), .sw_pool_addr_z(sw_pool_addr_z),
        .sw_pool_x_m(sw_pool_x_m), .sw_pool_x_n(sw_pool_x_n),
        .sw_pool_y_m(sw_pool_y_m), .sw_pool_y_n(sw_pool_y_n),
        .sw_pool_go(sw_pool_go), .sw_pool_done(sw_pool_done),
        .pool_sw_busy_ind(pool_sw_busy_ind),
        .rd_mem_req(rd_mem_req), .rd_mem_start_addr(rd_mem_start_addr),
        .rd_mem_size_bytes(rd_mem_size_bytes), .rd_mem_valid(rd_mem_valid),
        .rd_last(rd_last), .rd_mem_data(rd_mem_data),
        .rd_mem_last_valid(rd_mem_last_valid),
        .wr_mem_req(wr_mem_req), .wr_mem_start_addr(wr_mem_start_addr),
        .wr_mem_size_bytes(wr_mem_size_bytes), .wr_mem_data(wr_mem_data),
        .wr_mem_ack(wr_mem_ack), .data2write_out(data2write_out)
    );

    logic [7:0] mem [0:65535];
    int pic [0:4095];
    int exp_rd[$], exp_wa[$], exp_wv[$];
    int total = 0, bad = 0;
    int cur_yn, rd_lat, wr_lat;
    int done_cnt = 0, wr_seen, ones_cnt, first_val, first_wa, last_wa, first_rd;
    bit rd_busy = 0, wr_busy = 0, prev_done = 0;
    int rd_cur, rd_cnt, wr_cnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic int pick_lat(input int l);
        return (l < 0) ? int'($urandom_range(0, 3)) : l;
    endfunction

    // Memory responder and output checker, acting on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_busy = 0; wr_busy = 0; prev_done = 0;
            rd_mem_valid = 0; wr_mem_ack = 0;
            exp_rd.delete(); exp_wa.delete(); exp_wv.delete();
        end else begin
            if (prev_done) chk("done_pulse_width", sw_pool_done, 0);
            if (sw_pool_done) begin
                done_cnt++;
                chk("busy_at_done", pool_sw_busy_ind, 1);
            end
            prev_done = sw_pool_done;

            rd_last = 1'($urandom);
            rd_mem_last_valid = 5'($urandom);
            if (rd_mem_valid) begin
                rd_mem_valid = 0; rd_busy = 0;
                for (int j = 0; j < 8; j++) rd_mem_data[j*32 +: 32] = $urandom;
                chk("rd_req_release", rd_mem_req, 0);
            end else begin
                if (!rd_busy && rd_mem_req) begin
                    if (exp_rd.size() == 0) chk("rd_unexpected", rd_mem_req, 0);
                    else begin
                        rd_cur = exp_rd.pop_front();
                        if (first_rd < 0) first_rd = int'(rd_mem_start_addr);
                        chk("rd_addr", rd_mem_start_addr, rd_cur);
                        chk("rd_size", rd_mem_size_bytes, cur_yn);
                        chk("rd_during_wr", wr_mem_req, 0);
                        rd_busy = 1;
                        rd_cnt = pick_lat(rd_lat);
                    end
                end else if (rd_busy) begin
                    chk("rd_req_hold", rd_mem_req, 1);
                    chk("rd_addr_hold", rd_mem_start_addr, rd_cur);
                end
                if (rd_busy) begin
                    if (rd_cnt == 0) begin
                        for (int j = 0; j < 32; j++) rd_mem_data[j*8 +: 8] = mem[(rd_cur + j) & 16'hffff];
                        rd_mem_valid = 1;
                    end else rd_cnt--;
                end
            end

            if (wr_mem_ack) begin
                wr_mem_ack = 0; wr_busy = 0;
                chk("wr_req_release", wr_mem_req, 0);
            end else begin
                if (!wr_busy && wr_mem_req) begin
                    if (exp_wa.size() == 0) chk("wr_unexpected", wr_mem_req, 0);
                    else begin
                        int a, v;
                        a = exp_wa.pop_front();
                        v = exp_wv.pop_front();
                        chk("wr_addr", wr_mem_start_addr, a);
                        chk("wr_data", wr_mem_data[7:0], v);
                        chk("wr_data_hi", wr_mem_data[255:8] == '0, 1);
                        chk("d2w_out", data2write_out, v);
                        chk("wr_size", wr_mem_size_bytes, 1);
                        if (wr_seen == 0) begin
                            first_val = int'(wr_mem_data[7:0]);
                            first_wa  = int'(wr_mem_start_addr);
                        end
                        last_wa = int'(wr_mem_start_addr);
                        if (wr_mem_data[7:0] == 8'd1) ones_cnt++;
                        wr_seen++;
                        wr_busy = 1;
                        wr_cnt = pick_lat(wr_lat);
                    end
                end else if (wr_busy) begin
                    chk("wr_req_hold", wr_mem_req, 1);
                    chk("no_rd_before_ack", rd_mem_req, 0);
                end
                if (wr_busy) begin
                    if (wr_cnt == 0) wr_mem_ack = 1;
                    else wr_cnt--;
                end
            end
        end
    end

    task automatic start_job(input int xm, xn, ym, yn, ax, az, mode, rl, wl);
        int orr, occ, s;
        for (int i = 0; i < xm * xn; i++) begin
            case (mode)
                0: pic[i] = i % 256;
                1: pic[i] = 255;
                2: pic[i] = (i == 4 * xn + 4) ? 64 : 0;
                default: pic[i] = int'($urandom_range(0, 255));
            endcase
            mem[ax + i] = 8'(pic[i]);
        end
        orr = (xm - ym) / JR + 1;
        occ = (xn - yn) / JC + 1;
        for (int r = 0; r < orr; r++)
            for (int c = 0; c < occ; c++) begin
                s = 0;
                for (int u = 0; u < ym; u++) begin
                    exp_rd.push_back(ax + (r * JR + u) * xn + c * JC);
                    for (int v = 0; v < yn; v++) s += pic[(r * JR + u) * xn + c * JC + v];
                end
                exp_wa.push_back(az + r * occ + c);
                exp_wv.push_back(s / (ym * yn));
            end
        cur_yn = yn; rd_lat = rl; wr_lat = wl;
        wr_seen = 0; ones_cnt = 0; first_val = -1; first_wa = -1; last_wa = -1; first_rd = -1;
        @(negedge clk);
        sw_pool_addr_x = AW'(ax); sw_pool_addr_z = AW'(az);
        sw_pool_x_m = 8'(xm); sw_pool_x_n = 8'(xn);
        sw_pool_y_m = 4'(ym); sw_pool_y_n = 4'(yn);
        sw_pool_go = 1;
        // Config changes after start must be ignored.
        @(negedge clk);
        sw_pool_addr_x = AW'($urandom); sw_pool_x_n = 8'($urandom);
        sw_pool_y_m = 4'($urandom); sw_pool_y_n = 4'($urandom);
    endtask

    task automatic finish_job(input bit toggle);
        int d0, cyc;
        d0 = done_cnt - (sw_pool_done ? 1 : 0);
        cyc = 0;
        while (done_cnt == d0 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            if (toggle && cyc < 200 && cyc % 37 == 0) sw_pool_go = ~sw_pool_go;
        end
        chk("job_done", done_cnt - d0, 1);
        repeat (10) @(negedge clk);
        chk("idle_after_done", pool_sw_busy_ind, 0);
        chk("single_done", done_cnt - d0, 1);
        chk("rd_all_issued", exp_rd.size(), 0);
        chk("wr_all_issued", exp_wa.size(), 0);
        sw_pool_go = 0;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        chk("rst_rd_req", rd_mem_req, 0);
        chk("rst_rd_addr", rd_mem_start_addr, 0);
        chk("rst_rd_size", rd_mem_size_bytes, 0);
        chk("rst_wr_req", wr_mem_req, 0);
        chk("rst_wr_addr", wr_mem_start_addr, 0);
        chk("rst_wr_size", wr_mem_size_bytes, 0);
        chk("rst_wr_data", wr_mem_data == '0, 1);
        chk("rst_done", sw_pool_done, 0);
        chk("rst_busy", pool_sw_busy_ind, 0);
        chk("rst_d2w", data2write_out, 0);
    endtask

    initial begin
        int xm, xn, ym, yn, d0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rst_n = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1;
        @(negedge clk);

        // Ramp picture: first 8x8 window over pitch 32 averages to 115.
        start_job(32, 32, 8, 8, 'h100, 'h9000, 0, -1, -1);
        finish_job(0);
        chk("ramp_first_val", first_val, 115);
        chk("ramp_writes", wr_seen, 625);

        start_job(16, 16, 8, 8, 'h2000, 'h9800, 1, -1, -1);
        finish_job(0);
        chk("sat_first_val", first_val, 255);
        chk("sat_writes", wr_seen, 81);

        // Spike picture with slow read valid and slow write ack.
        start_job(16, 16, 8, 8, 'h3000, 'hA000, 2, 5, 3);
        finish_job(0);
        chk("spike_ones", ones_cnt, 25);
        chk("spike_writes", wr_seen, 81);
        chk("spike_first_addr", first_wa, 'hA000);
        chk("spike_last_addr", last_wa, 'hA000 + 80);

        start_job(8, 4, 8, 4, 'h4000, 'hB000, 3, -1, -1);
        finish_job(0);
        chk("one_window", wr_seen, 1);

        for (int k = 0; k < 6; k++) begin
            xm = int'($urandom_range(1, 20));
            xn = int'($urandom_range(1, 20));
            ym = 1 << $urandom_range(0, 3);
            yn = 1 << $urandom_range(0, 3);
            while (ym > xm) ym = ym / 2;
            while (yn > xn) yn = yn / 2;
            start_job(xm, xn, ym, yn, 'h5000 + k * 512, 'hC000 + k * 512, 3, -1, -1);
            finish_job(k[0]);
        end

        // Reset in the middle of a job, then a clean restart.
        start_job(32, 24, 4, 4, 'h6000, 'hD000, 3, -1, -1);
        repeat (300) @(negedge clk);
        d0 = done_cnt;
        chk("midjob_busy", pool_sw_busy_ind, 1);
        rst_n = 0;
        sw_pool_go = 0;
        @(negedge clk);
        check_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (20) @(negedge clk);
        chk("no_done_after_abort", done_cnt, d0);
        chk("idle_after_abort", pool_sw_busy_ind, 0);
        start_job(32, 24, 4, 4, 'h6000, 'hD000, 3, -1, -1);
        finish_job(1);
        chk("restart_first_rd", first_rd, 'h6000);
        chk("restart_first_wr", first_wa, 'hD000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
